// File: rtl/dmem_responder.sv
// Data-side responder for the CPU dmem port: direct-mapped, word-line, write-through,
// no-write-allocate cache in flops, backed by a variable-latency word-wide pmem port.
module dmem_responder #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_resp,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [3:0]  pmem_byte_enable,
    output logic [31:0] pmem_wdata,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic [1:0]  o_dbg_state
);
    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = 30 - IDX_BITS;

    // Handshake: dmem_resp=1 means the op presented this cycle completes at the
    // coming edge; the CPU holds its request stable while dmem_resp=0. The pmem side
    // holds pmem_read/pmem_write and their fields until the one-cycle pmem_resp pulse.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MISS_RD = 2'd1,
        S_WR      = 2'd2
    } state_t;

    state_t r_state, w_next_state;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_line [LINES];

    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic [IDX_BITS-1:0] w_idx, w_lidx;
    logic [TAG_W-1:0]    w_tag, w_ltag;
    logic                w_hit, w_lhit;
    logic                w_latch, w_fill, w_merge, w_resp_rd;
    logic [31:0]         w_resp_data, w_merged;

    assign w_idx  = dmem_address[IDX_BITS+1:2];
    assign w_tag  = dmem_address[31:IDX_BITS+2];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lidx = r_addr[IDX_BITS+1:2];
    assign w_ltag = r_addr[31:IDX_BITS+2];
    assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);

    always_comb begin
        w_merged = r_line[w_lidx];
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    always_comb begin
        w_next_state = r_state;
        dmem_resp    = 1'b0;
        w_latch      = 1'b0;
        w_fill       = 1'b0;
        w_merge      = 1'b0;
        w_resp_rd    = 1'b0;
        w_resp_data  = 32'h0;
        case (r_state)
            S_IDLE: begin
                // A write wins when read and write are both raised.
                if (dmem_write) begin
                    w_latch      = 1'b1;
                    w_next_state = S_WR;
                end else if (dmem_read) begin
                    if (w_hit) begin
                        dmem_resp   = 1'b1;
                        w_resp_rd   = 1'b1;
                        w_resp_data = r_line[w_idx];
                    end else begin
                        w_latch      = 1'b1;
                        w_next_state = S_MISS_RD;
                    end
                end else begin
                    dmem_resp = 1'b1;
                end
            end
            S_MISS_RD: begin
                if (pmem_resp) begin
                    dmem_resp    = 1'b1;
                    w_resp_rd    = 1'b1;
                    w_resp_data  = pmem_rdata;
                    w_fill       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_WR: begin
                if (pmem_resp) begin
                    dmem_resp    = 1'b1;
                    w_merge      = w_lhit;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_addr  <= 32'h0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_addr  <= dmem_address;
                r_be    <= dmem_byte_enable;
                r_wdata <= dmem_wdata;
            end
            if (w_fill) r_valid[w_lidx] <= 1'b1;
            // Response regs move only on completion so a parked load keeps its data.
            if (dmem_resp) begin
                r_ready <= w_resp_rd;
                if (w_resp_rd) r_rdata <= w_resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_tag[w_lidx]  <= w_ltag;
                r_line[w_lidx] <= pmem_rdata;
            end else if (w_merge) begin
                r_line[w_lidx] <= w_merged;
            end
        end
    end

    assign dmem_ready       = r_ready;
    assign dmem_rdata       = r_rdata;
    assign pmem_read        = (r_state == S_MISS_RD);
    assign pmem_write       = (r_state == S_WR);
    assign pmem_address     = r_addr;
    assign pmem_byte_enable = r_be;
    assign pmem_wdata       = r_wdata;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: the bench plays the CPU and a pmem with
// per-operation latency, and checks every scenario against hand-computed values.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp, dmem_ready;
    logic [31:0] dmem_rdata;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [1:0]  o_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          hit;
        bit          idle_pmem;
        bit          early_resp;
        bit          resp_at_pulse;
        bit          saw_pread;
        bit          saw_pwrite;
        bit          pmem_stable;
        bit          hold_ok;
        logic [31:0] cap_addr;
        logic [3:0]  cap_be;
        logic [31:0] cap_wdata;
        logic        ready_after;
        logic [31:0] rdata_after;
    } obs_t;

    dmem_responder #(.IDX_BITS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_resp        (dmem_resp),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .o_dbg_state      (o_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang exp completion");
        $fatal(1, "watchdog");
    end

    // Driver: presents one CPU op at a negedge and, on a miss/write, answers the
    // pmem side after lat wait cycles. Returns observations only; no checking here.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input int lat, input logic [31:0] prdata, output obs_t o);
        logic        r0;
        logic [31:0] d0;
        o = '{default: '0};
        @(negedge clk);
        dmem_read        = rd;
        dmem_write       = wr;
        dmem_address     = addr;
        dmem_byte_enable = be;
        dmem_wdata       = wdata;
        #1;
        r0          = dmem_ready;
        d0          = dmem_rdata;
        o.hold_ok   = 1'b1;
        o.idle_pmem = !pmem_read && !pmem_write;
        if (dmem_resp) begin
            o.hit = 1'b1;
            @(posedge clk);
        end else begin
            o.pmem_stable = 1'b1;
            @(posedge clk);
            for (int w = 0; w <= lat; w++) begin
                @(negedge clk);
                #1;
                if (w == 0) begin
                    o.saw_pread  = pmem_read;
                    o.saw_pwrite = pmem_write;
                    o.cap_addr   = pmem_address;
                    o.cap_be     = pmem_byte_enable;
                    o.cap_wdata  = pmem_wdata;
                end else if (pmem_read !== o.saw_pread || pmem_write !== o.saw_pwrite ||
                             pmem_address !== o.cap_addr || pmem_byte_enable !== o.cap_be ||
                             pmem_wdata !== o.cap_wdata) begin
                    o.pmem_stable = 1'b0;
                end
                if (dmem_ready !== r0 || dmem_rdata !== d0) o.hold_ok = 1'b0;
                if (w < lat) begin
                    if (dmem_resp) o.early_resp = 1'b1;
                    @(posedge clk);
                end else begin
                    pmem_rdata = prdata;
                    pmem_resp  = 1'b1;
                    #1;
                    o.resp_at_pulse = dmem_resp;
                    @(posedge clk);
                end
            end
        end
        #1;
        pmem_resp     = 1'b0;
        o.ready_after = dmem_ready;
        o.rdata_after = dmem_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0;
        dmem_byte_enable = '0; dmem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (dmem_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b exp 0", dmem_ready); end
        n_vec++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0", dmem_rdata); end
        n_vec++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_err++; $display("FAIL reset_pmem: got rd=%0b wr=%0b exp 0/0", pmem_read, pmem_write); end
        n_vec++; if (dmem_resp !== 1'b1) begin n_err++; $display("FAIL reset_idle_resp: got %0b exp 1", dmem_resp); end
        n_vec++; if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", o_dbg_state); end
    endtask

    task automatic test_read_miss();
        obs_t o;
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 3, 32'hDEADBEEF, o);
        n_vec++; if (o.hit !== 1'b0) begin n_err++; $display("FAIL miss1_hit: got %0b exp 0", o.hit); end
        n_vec++; if (o.saw_pread !== 1'b1 || o.saw_pwrite !== 1'b0) begin n_err++; $display("FAIL miss1_pread: got rd=%0b wr=%0b exp 1/0", o.saw_pread, o.saw_pwrite); end
        n_vec++; if (o.cap_addr !== 32'h100) begin n_err++; $display("FAIL miss1_addr: got %h exp 00000100", o.cap_addr); end
        n_vec++; if (o.pmem_stable !== 1'b1) begin n_err++; $display("FAIL miss1_stable: got %0b exp 1", o.pmem_stable); end
        n_vec++; if (o.early_resp !== 1'b0 || o.resp_at_pulse !== 1'b1) begin n_err++; $display("FAIL miss1_resp_timing: got early=%0b pulse=%0b exp 0/1", o.early_resp, o.resp_at_pulse); end
        n_vec++; if (o.ready_after !== 1'b1) begin n_err++; $display("FAIL miss1_ready: got %0b exp 1", o.ready_after); end
        n_vec++; if (o.rdata_after !== 32'hDEADBEEF) begin n_err++; $display("FAIL miss1_rdata: got %h exp deadbeef", o.rdata_after); end
    endtask

    task automatic test_read_hit();
        obs_t o;
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1) begin n_err++; $display("FAIL hit_resp: got %0b exp 1", o.hit); end
        n_vec++; if (o.idle_pmem !== 1'b1) begin n_err++; $display("FAIL hit_no_pmem: got %0b exp 1", o.idle_pmem); end
        n_vec++; if (o.ready_after !== 1'b1 || o.rdata_after !== 32'hDEADBEEF) begin n_err++; $display("FAIL hit_rdata: got rdy=%0b %h exp 1 deadbeef", o.ready_after, o.rdata_after); end
    endtask

    task automatic test_write_hit_merge();
        obs_t o;
        run_op(1'b0, 1'b1, 32'h100, 4'h2, 32'h0000AA00, 2, 32'h0, o);
        n_vec++; if (o.hit !== 1'b0 || o.saw_pwrite !== 1'b1 || o.saw_pread !== 1'b0) begin n_err++; $display("FAIL wr_pwrite: got hit=%0b wr=%0b rd=%0b exp 0/1/0", o.hit, o.saw_pwrite, o.saw_pread); end
        n_vec++; if (o.cap_addr !== 32'h100 || o.cap_be !== 4'h2 || o.cap_wdata !== 32'h0000AA00) begin n_err++; $display("FAIL wr_fields: got %h %h %h exp 00000100 2 0000aa00", o.cap_addr, o.cap_be, o.cap_wdata); end
        n_vec++; if (o.early_resp !== 1'b0 || o.resp_at_pulse !== 1'b1 || o.pmem_stable !== 1'b1) begin n_err++; $display("FAIL wr_timing: got early=%0b pulse=%0b stable=%0b exp 0/1/1", o.early_resp, o.resp_at_pulse, o.pmem_stable); end
        n_vec++; if (o.ready_after !== 1'b0 || o.rdata_after !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_resp_regs: got rdy=%0b %h exp 0 deadbeef", o.ready_after, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1 || o.rdata_after !== 32'hDEADAAEF) begin n_err++; $display("FAIL wr_merge: got hit=%0b %h exp 1 deadaaef", o.hit, o.rdata_after); end
    endtask

    task automatic test_write_miss_no_alloc();
        obs_t o;
        run_op(1'b0, 1'b1, 32'h200, 4'hF, 32'h55667788, 1, 32'h0, o);
        n_vec++; if (o.saw_pwrite !== 1'b1 || o.saw_pread !== 1'b0) begin n_err++; $display("FAIL wmiss_pmem: got wr=%0b rd=%0b exp 1/0", o.saw_pwrite, o.saw_pread); end
        run_op(1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 2, 32'h12345678, o);
        n_vec++; if (o.hit !== 1'b0 || o.saw_pread !== 1'b1) begin n_err++; $display("FAIL wmiss_noalloc: got hit=%0b rd=%0b exp 0/1", o.hit, o.saw_pread); end
        n_vec++; if (o.rdata_after !== 32'h12345678) begin n_err++; $display("FAIL wmiss_fill_data: got %h exp 12345678", o.rdata_after); end
    endtask

    task automatic test_conflict();
        obs_t o;
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1, 32'h0BAD0100, o);
        n_vec++; if (o.hit !== 1'b0 || o.rdata_after !== 32'h0BAD0100) begin n_err++; $display("FAIL conf_evicted: got hit=%0b %h exp 0 0bad0100", o.hit, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1 || o.rdata_after !== 32'h0BAD0100) begin n_err++; $display("FAIL conf_b2b_hit: got hit=%0b %h exp 1 0bad0100", o.hit, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, 2, 32'h01400140, o);
        n_vec++; if (o.hit !== 1'b0 || o.cap_addr !== 32'h140 || o.rdata_after !== 32'h01400140) begin n_err++; $display("FAIL conf_140_miss: got hit=%0b %h %h exp 0 00000140 01400140", o.hit, o.cap_addr, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1 || o.rdata_after !== 32'h01400140) begin n_err++; $display("FAIL conf_140_hit: got hit=%0b %h exp 1 01400140", o.hit, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1, 32'h0BAD0100, o);
        n_vec++; if (o.hit !== 1'b0 || o.saw_pread !== 1'b1) begin n_err++; $display("FAIL conf_100_remiss: got hit=%0b rd=%0b exp 0/1", o.hit, o.saw_pread); end
    endtask

    task automatic test_write_corner();
        obs_t o;
        run_op(1'b0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 1, 32'h0, o);
        n_vec++; if (o.saw_pwrite !== 1'b1 || o.cap_be !== 4'h0 || o.resp_at_pulse !== 1'b1) begin n_err++; $display("FAIL be0_forward: got wr=%0b be=%h pulse=%0b exp 1/0/1", o.saw_pwrite, o.cap_be, o.resp_at_pulse); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1 || o.rdata_after !== 32'h0BAD0100) begin n_err++; $display("FAIL be0_nochange: got hit=%0b %h exp 1 0bad0100", o.hit, o.rdata_after); end
        run_op(1'b1, 1'b1, 32'h100, 4'h1, 32'h00000055, 1, 32'h0, o);
        n_vec++; if (o.saw_pwrite !== 1'b1 || o.saw_pread !== 1'b0 || o.ready_after !== 1'b0) begin n_err++; $display("FAIL rdwr_as_write: got wr=%0b rd=%0b rdy=%0b exp 1/0/0", o.saw_pwrite, o.saw_pread, o.ready_after); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1 || o.rdata_after !== 32'h0BAD0155) begin n_err++; $display("FAIL rdwr_merge: got hit=%0b %h exp 1 0bad0155", o.hit, o.rdata_after); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.ready_after !== 1'b1 || o.rdata_after !== 32'h0BAD0155) begin n_err++; $display("FAIL b2b_load: got rdy=%0b %h exp 1 0bad0155", o.ready_after, o.rdata_after); end
        run_op(1'b0, 1'b1, 32'h300, 4'hF, 32'h11111111, 5, 32'h0, o);
        n_vec++; if (o.hold_ok !== 1'b1) begin n_err++; $display("FAIL b2b_hold: got %0b exp 1", o.hold_ok); end
        n_vec++; if (o.early_resp !== 1'b0 || o.resp_at_pulse !== 1'b1 || o.pmem_stable !== 1'b1) begin n_err++; $display("FAIL b2b_store_timing: got early=%0b pulse=%0b stable=%0b exp 0/1/1", o.early_resp, o.resp_at_pulse, o.pmem_stable); end
        n_vec++; if (o.ready_after !== 1'b0 || o.rdata_after !== 32'h0BAD0155) begin n_err++; $display("FAIL b2b_after_store: got rdy=%0b %h exp 0 0bad0155", o.ready_after, o.rdata_after); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 0, 32'h0, o);
        n_vec++; if (o.hit !== 1'b1) begin n_err++; $display("FAIL b2b_store_noalloc: got hit=%0b exp 1", o.hit); end
    endtask

    task automatic test_reset_mid_miss();
        obs_t o;
        @(negedge clk);
        dmem_read = 1'b1; dmem_write = 1'b0; dmem_address = 32'h140;
        #1;
        n_vec++; if (dmem_resp !== 1'b0) begin n_err++; $display("FAIL rstm_lookup: got %0b exp 0", dmem_resp); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (pmem_read !== 1'b1) begin n_err++; $display("FAIL rstm_in_miss: got %0b exp 1", pmem_read); end
        rst = 1'b1;
        dmem_read = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || o_dbg_state !== 2'd0) begin n_err++; $display("FAIL rstm_abandon: got rd=%0b wr=%0b st=%0d exp 0/0/0", pmem_read, pmem_write, o_dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        pmem_rdata = 32'hFFFFFFFF;
        pmem_resp = 1'b1;
        #1;
        n_vec++; if (dmem_resp !== 1'b1) begin n_err++; $display("FAIL rstm_stray_resp: got %0b exp 1", dmem_resp); end
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        n_vec++; if (o_dbg_state !== 2'd0 || pmem_read !== 1'b0 || dmem_ready !== 1'b0) begin n_err++; $display("FAIL rstm_stray_ignored: got st=%0d rd=%0b rdy=%0b exp 0/0/0", o_dbg_state, pmem_read, dmem_ready); end
        run_op(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 2, 32'h77778888, o);
        n_vec++; if (o.hit !== 1'b0 || o.saw_pread !== 1'b1) begin n_err++; $display("FAIL rstm_invalidated: got hit=%0b rd=%0b exp 0/1", o.hit, o.saw_pread); end
        n_vec++; if (o.rdata_after !== 32'h77778888) begin n_err++; $display("FAIL rstm_refill: got %h exp 77778888", o.rdata_after); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit_merge();
        test_write_miss_no_alloc();
        test_conflict();
        test_write_corner();
        test_back_to_back();
        test_reset_mid_miss();
        @(negedge clk);
        dmem_read = 1'b0; dmem_write = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
